// File: rtl/round_decrypt.sv
// Iterative AES inverse cipher: one round per clock, Nr = 10/12/14 chosen by switch.
// Round keys are fetched by index from an external expanded-key store, never stored here.
module round_decrypt (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   switch,
    input  logic [127:0] data_in,
    input  logic [127:0] round_key,
    output logic [3:0]   key_idx,
    output logic [127:0] data_out,
    output logic         busy,
    output logic         done,
    output logic [9:0]   dbg_fsm
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // State bytes are column-major: byte 4*c+r is row r of column c, byte 0 in [127:120].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8*i -: 8] = INV_SBOX[s[127 - 8*i -: 8]];
        end
        return o;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    state_t         r_state;
    logic [127:0]   r_st;
    logic [3:0]     r_rnd;
    logic [3:0]     r_nr;
    logic [127:0]   r_data_out;
    logic           r_done;

    logic [3:0]     w_nr_live;
    logic [127:0]   w_isr;
    logic [127:0]   w_isb;
    logic [127:0]   w_ark;
    logic [127:0]   w_imc;

    always_comb begin
        w_nr_live = 4'd14;
        case (switch)
            2'b00:   w_nr_live = 4'd10;
            2'b01:   w_nr_live = 4'd12;
            default: w_nr_live = 4'd14;
        endcase
    end

    // The same InvShiftRows/InvSubBytes/AddRoundKey chain serves both ROUND and FINAL.
    assign w_isr = inv_shift_rows(r_st);
    assign w_isb = inv_sub_bytes(w_isr);
    assign w_ark = w_isb ^ round_key;
    assign w_imc = inv_mix_columns(w_ark);

    always_comb begin
        key_idx = 4'd0;
        case (r_state)
            S_IDLE:  key_idx = w_nr_live;
            S_ROUND: key_idx = r_rnd;
            default: key_idx = 4'd0;
        endcase
    end

    // Handshake: start is taken only in IDLE; busy stays high until the FINAL round
    // retires, and done pulses for exactly the cycle in which data_out first shows the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_st       <= '0;
            r_rnd      <= 4'd0;
            r_nr       <= 4'd10;
            r_data_out <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_st    <= data_in ^ round_key;
                        r_nr    <= w_nr_live;
                        r_rnd   <= w_nr_live - 4'd1;
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_st <= w_imc;
                    if (r_rnd == 4'd1) begin
                        r_state <= S_FINAL;
                    end else begin
                        r_rnd <= r_rnd - 4'd1;
                    end
                end
                S_FINAL: begin
                    r_data_out <= w_ark;
                    r_done     <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign data_out = r_data_out;
    assign dbg_fsm  = {r_state, r_rnd, r_nr};

endmodule
